pc_unit: RTL

- Parametrised program-counter unit; next generation of the single-cycle PC register.
- Holds the fetch address and selects the next PC from several sources: sequential increment, branch, jump, exception vector, or exception return.
- Supports stall and a boot/exception bubble, and saves an exception PC (EPC).
- Sits between the next-PC logic and instruction memory in the fetch stage.

---
 rtl/pc_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Fetch-stage program counter: selects the next PC from sequential, branch,
// jump, exception-vector or exception-return sources; saves EPC on exceptions.
// Optional build macro PC_ALIGN_CHECK_EN traps misaligned redirect targets.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter int               INC          = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             exc,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             pc_valid,
  output logic [WIDTH-1:0] epc,
  output logic             redirected,
  output logic             misalign
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_EXC  = 2'd2
  } state_t;

  typedef struct packed {
    logic             hit;
    logic [WIDTH-1:0] addr;
  } redirect_t;

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  state_t           state, stateNext;
  logic [WIDTH-1:0] pcNext, epcNext;
  logic             redirNext;
  redirect_t        redir;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);
  logic misNext;
`endif

  assign pc_plus = pc + INC_W;

  // Only the highest-priority redirect target is considered (and checked).
  always_comb begin
    redir = '0;
    if (eret) begin
      redir.hit  = 1'b1;
      redir.addr = epc;
    end else if (jmp) begin
      redir.hit  = 1'b1;
      redir.addr = jmp_target;
    end else if (br_taken) begin
      redir.hit  = 1'b1;
      redir.addr = br_target;
    end
  end

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    epcNext   = epc;
    redirNext = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    misNext   = 1'b0;
`endif
    case (state)
      ST_RUN: begin
        if (exc) begin
          epcNext   = pc;
          pcNext    = EXC_VECTOR;
          redirNext = 1'b1;
          stateNext = ST_EXC;
        end else if (redir.hit) begin
`ifdef PC_ALIGN_CHECK_EN
          if ((redir.addr & ALIGN_MASK) != '0) begin
            misNext   = 1'b1;
            epcNext   = pc;
            pcNext    = EXC_VECTOR;
            redirNext = 1'b1;
            stateNext = ST_EXC;
          end else
`endif
          begin
            pcNext    = redir.addr;
            redirNext = 1'b1;
          end
        end else if (!stall) begin
          pcNext = pc_plus;
        end
      end
      // Boot and exception bubbles hold pc and ignore every input.
      default: stateNext = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_BOOT;
      pc         <= RESET_VECTOR;
      epc        <= '0;
      pc_valid   <= 1'b0;
      redirected <= 1'b0;
    end else begin
      state      <= stateNext;
      pc         <= pcNext;
      epc        <= epcNext;
      pc_valid   <= (stateNext == ST_RUN);
      redirected <= redirNext;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= misNext;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule
